// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the pipeline hazard controller.
package hazard_pkg;

    // Tuse: the stage where an operand is first read. TUSE_NONE means it is not read.
    localparam logic [1:0] TUSE_D    = 2'd0;
    localparam logic [1:0] TUSE_E    = 2'd1;
    localparam logic [1:0] TUSE_M    = 2'd2;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // Tnew: cycles after entering E until the result can be forwarded.
    localparam logic [1:0] TNEW_JAL  = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Forwarding mux selects. FWD_E is only meaningful on the D-stage muxes.
    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_W   = 2'd1;
    localparam logic [1:0] FWD_M   = 2'd2;
    localparam logic [1:0] FWD_E   = 2'd3;

    // Default HI/LO unit latencies, counted from the cycle after E.
    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    // Shadow of the ID/EX pipeline register.
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       start;
        logic       op;
    } e_stage_t;

    // Shadow of the EX/MEM pipeline register.
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic [4:0] rt;
    } m_stage_t;

    // Tnew counts down as the instruction advances, but never below zero.
    function automatic logic [1:0] sat_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // $0 is hard-wired, so it never produces a dependency.
    function automatic logic reg_match(input logic [4:0] r, input logic [4:0] dst);
        return (r != 5'd0) && (r == dst);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
interface pipe_hazard_ctrl_if;

    // Decode-stage instruction description
    logic [4:0] D_Rs;
    logic [4:0] D_Rt;
    logic [1:0] D_TuseRs;
    logic [1:0] D_TuseRt;
    logic [4:0] D_Dst;
    logic [1:0] D_Tnew;
    logic       D_IsMD;
    logic       D_MDStart;
    logic       D_MDOp;

    // Pipeline control back to the datapath
    logic       Stall;
    logic [1:0] FwdD_Rs;
    logic [1:0] FwdD_Rt;
    logic [1:0] FwdE_Rs;
    logic [1:0] FwdE_Rt;
    logic       FwdM_Rt;
    logic       MD_Busy;

    // Datapath side: describes the D instruction, obeys stall/forward controls.
    modport master (
        output D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_Dst, D_Tnew,
               D_IsMD, D_MDStart, D_MDOp,
        input  Stall, FwdD_Rs, FwdD_Rt, FwdE_Rs, FwdE_Rt, FwdM_Rt, MD_Busy
    );

    // Controller side.
    modport slave (
        input  D_Rs, D_Rt, D_TuseRs, D_TuseRt, D_Dst, D_Tnew,
               D_IsMD, D_MDStart, D_MDOp,
        output Stall, FwdD_Rs, FwdD_Rt, FwdE_Rs, FwdE_Rt, FwdM_Rt, MD_Busy
    );

endinterface

// File: rtl/md_busy_timer.sv
// HI/LO multiply/divide busy timer.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | unit free; busy only if a start is sitting in E this cycle
//   BUSY   | down-counter running; leaves on the edge where cnt is 1
module md_busy_timer
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic op,
    output logic busy
);

    localparam int CYC_MAX = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CW      = $clog2(CYC_MAX + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYC);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYC);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] cnt;

    // Load the latency on a start, count down to the terminal value while busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                state <= S_BUSY;
                cnt   <= op ? DIV_LOAD : MULT_LOAD;
            end
        end else begin
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
                state <= S_IDLE;
            end
        end
    end

    // The start cycle itself already counts as busy, so dependants stall at once.
    assign busy = start || (state == S_BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/forward controller for the 5-stage pipeline. Mirrors dst/Tnew
// of the E, M and W pipeline registers and derives every stall and bypass
// select from that shadow plus the instruction currently in D.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    e_stage_t   e_q;
    m_stage_t   m_q;
    logic [4:0] w_dst;

    logic stall;
    logic stall_data;
    logic stall_md;
    logic md_busy;

    logic [1:0] fwd_d_rs;
    logic [1:0] fwd_d_rt;
    logic [1:0] fwd_e_rs;
    logic [1:0] fwd_e_rt;
    logic       fwd_m_rt;

    // A stalled D instruction must not start the unit, so the timer watches E.
    md_busy_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .start (e_q.start),
        .op    (e_q.op),
        .busy  (md_busy)
    );

    // Operand s stalls D if its producer cannot deliver before s is needed.
    function automatic logic operand_stall(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        if (tuse == TUSE_NONE) begin
            return 1'b0;
        end
        return (reg_match(src, e_dst) && (e_tnew > tuse)) ||
               (reg_match(src, m_dst) && (m_tnew > tuse));
    endfunction

    // Youngest ready producer wins; E only ever holds a ready value for jal (PC8).
    function automatic logic [1:0] fwd_d_sel(
        input logic [4:0] src,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew,
        input logic [4:0] wb_dst
    );
        if (reg_match(src, e_dst) && (e_tnew == 2'd0)) begin
            return FWD_E;
        end else if (reg_match(src, m_dst) && (m_tnew == 2'd0)) begin
            return FWD_M;
        end else if (reg_match(src, wb_dst)) begin
            return FWD_W;
        end
        return FWD_GRF;
    endfunction

    // E-stage bypass: M if its result is ready, else W, else the pipe register.
    function automatic logic [1:0] fwd_e_sel(
        input logic [4:0] src,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew,
        input logic [4:0] wb_dst
    );
        if (reg_match(src, m_dst) && (m_tnew == 2'd0)) begin
            return FWD_M;
        end else if (reg_match(src, wb_dst)) begin
            return FWD_W;
        end
        return FWD_GRF;
    endfunction

    // Advance the shadow scoreboard; a stall turns the E slot into a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q   <= '0;
            m_q   <= '0;
            w_dst <= '0;
        end else begin
            if (stall) begin
                e_q <= '0;
            end else begin
                e_q <= '{
                    dst:   hz.D_Dst,
                    tnew:  hz.D_Tnew,
                    rs:    hz.D_Rs,
                    rt:    hz.D_Rt,
                    start: hz.D_MDStart,
                    op:    hz.D_MDOp
                };
            end
            m_q <= '{
                dst:  e_q.dst,
                tnew: sat_dec(e_q.tnew),
                rt:   e_q.rt
            };
            w_dst <= m_q.dst;
        end
    end

    // Stall and forward decisions, purely combinational on shadow and D inputs.
    always_comb begin
        stall_data = 1'b0;
        stall_md   = 1'b0;
        fwd_d_rs   = FWD_GRF;
        fwd_d_rt   = FWD_GRF;
        fwd_e_rs   = FWD_GRF;
        fwd_e_rt   = FWD_GRF;
        fwd_m_rt   = 1'b0;

        stall_data = operand_stall(hz.D_Rs, hz.D_TuseRs, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew) ||
                     operand_stall(hz.D_Rt, hz.D_TuseRt, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew);
        stall_md   = hz.D_IsMD && md_busy;

        fwd_d_rs = fwd_d_sel(hz.D_Rs, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew, w_dst);
        fwd_d_rt = fwd_d_sel(hz.D_Rt, e_q.dst, e_q.tnew, m_q.dst, m_q.tnew, w_dst);
        fwd_e_rs = fwd_e_sel(e_q.rs, m_q.dst, m_q.tnew, w_dst);
        fwd_e_rt = fwd_e_sel(e_q.rt, m_q.dst, m_q.tnew, w_dst);
        fwd_m_rt = reg_match(m_q.rt, w_dst);
    end

    assign stall = stall_data || stall_md;

    assign hz.Stall   = stall;
    assign hz.FwdD_Rs = fwd_d_rs;
    assign hz.FwdD_Rt = fwd_d_rt;
    assign hz.FwdE_Rs = fwd_e_rs;
    assign hz.FwdE_Rt = fwd_e_rt;
    assign hz.FwdM_Rt = fwd_m_rt;
    assign hz.MD_Busy = md_busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Stimulus pushes hand-computed expected
// control vectors; a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;

    pipe_hazard_ctrl_if hif ();

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: {Stall, FwdD_Rs, FwdD_Rt, FwdE_Rs, FwdE_Rt, FwdM_Rt, MD_Busy}
    logic [10:0] exp_q[$];
    string       nm_q[$];
    int          total;
    int          bad;

    localparam logic [10:0] Z = 11'b0;

    function automatic logic [10:0] ex(
        input logic       stall,
        input logic [1:0] fdrs,
        input logic [1:0] fdrt,
        input logic [1:0] fers,
        input logic [1:0] fert,
        input logic       fmrt,
        input logic       busy
    );
        return {stall, fdrs, fdrt, fers, fert, fmrt, busy};
    endfunction

    // Monitor: the controller presents a full control vector every cycle.
    always @(negedge clk) begin
        logic [10:0] act;
        logic [10:0] want;
        string       nm;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            nm   = nm_q.pop_front();
            act  = {hif.Stall, hif.FwdD_Rs, hif.FwdD_Rt, hif.FwdE_Rs,
                    hif.FwdE_Rt, hif.FwdM_Rt, hif.MD_Busy};
            total++;
            if (act !== want) begin
                bad++;
                $display("FAIL %s: got stall=%b fdrs=%0d fdrt=%0d fers=%0d fert=%0d fmrt=%b busy=%b, want stall=%b fdrs=%0d fdrt=%0d fers=%0d fert=%0d fmrt=%b busy=%b",
                         nm, act[10], act[9:8], act[7:6], act[5:4], act[3:2], act[1], act[0],
                         want[10], want[9:8], want[7:6], want[5:4], want[3:2], want[1], want[0]);
            end
        end
    end

    // Present one D instruction for one cycle and queue its expected controls.
    task automatic cyc(
        input string      nm,
        input logic [4:0] rs,
        input logic [1:0] tur,
        input logic [4:0] rt,
        input logic [1:0] tut,
        input logic [4:0] dst,
        input logic [1:0] tnew,
        input logic       ismd,
        input logic       st,
        input logic       op,
        input logic [10:0] want
    );
        hif.D_Rs      = rs;
        hif.D_TuseRs  = tur;
        hif.D_Rt      = rt;
        hif.D_TuseRt  = tut;
        hif.D_Dst     = dst;
        hif.D_Tnew    = tnew;
        hif.D_IsMD    = ismd;
        hif.D_MDStart = st;
        hif.D_MDOp    = op;
        exp_q.push_back(want);
        nm_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input string nm, input logic [10:0] want);
        cyc(nm, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, want);
    endtask

    task automatic mflo(input string nm, input logic [10:0] want);
        cyc(nm, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, 1'b1, 1'b0, 1'b0, want);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) nop("flush", Z);
    endtask

    initial begin
        int guard;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        hif.D_Rs = '0; hif.D_TuseRs = 2'd3; hif.D_Rt = '0; hif.D_TuseRt = 2'd3;
        hif.D_Dst = '0; hif.D_Tnew = '0; hif.D_IsMD = 1'b0;
        hif.D_MDStart = 1'b0; hif.D_MDOp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nop("in_reset", Z);
        rst_n = 1'b1;
        nop("after_reset", Z);

        // lw $1 then add $2,$1,$1: one load-use bubble, then W bypass in E
        cyc("lw1",        5'd5, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2, 1'b0, 1'b0, 1'b0, Z);
        cyc("add_stall",  5'd1, 2'd1, 5'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("add_go",     5'd1, 2'd1, 5'd1, 2'd1, 5'd2, 2'd1, 1'b0, 1'b0, 1'b0, Z);
        nop("add_in_e",   ex(0, 0, 0, 1, 1, 0, 0));
        flush();

        // add $3 then beq $3,$0: one stall, then M bypass into D
        cyc("add3",       5'd7, 2'd1, 5'd8, 2'd1, 5'd3, 2'd1, 1'b0, 1'b0, 1'b0, Z);
        cyc("beq_stall",  5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(1, 0, 0, 0, 0, 0, 0));
        cyc("beq_go",     5'd3, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 2, 0, 0, 0, 0, 0));
        nop("beq_in_e",   ex(0, 0, 0, 1, 0, 0, 0));
        flush();

        // jal then jr $31: PC8 from E, then jr in E takes it from M
        cyc("jal",        5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, 1'b0, 1'b0, 1'b0, Z);
        cyc("jr",         5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 3, 0, 0, 0, 0, 0));
        nop("jr_in_e",    ex(0, 0, 0, 2, 0, 0, 0));
        flush();

        // lw $4 then sw $4: no stall, store data bypassed from W in M
        cyc("lw4",        5'd5, 2'd1, 5'd0, 2'd3, 5'd4, 2'd2, 1'b0, 1'b0, 1'b0, Z);
        cyc("sw4",        5'd5, 2'd1, 5'd4, 2'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, Z);
        nop("sw_in_e",    Z);
        nop("sw_in_m",    ex(0, 0, 0, 0, 0, 1, 0));
        flush();

        // add $6 then sub $9,$6: E takes rs from M
        cyc("add6",       5'd7, 2'd1, 5'd8, 2'd1, 5'd6, 2'd1, 1'b0, 1'b0, 1'b0, Z);
        cyc("sub_rs6",    5'd6, 2'd1, 5'd0, 2'd1, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0, Z);
        nop("sub_in_e",   ex(0, 0, 0, 2, 0, 0, 0));
        flush();

        // producer already in W: D bypass select 1 on both operands
        cyc("add10",      5'd7, 2'd1, 5'd8, 2'd1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0, Z);
        nop("gap1",       Z);
        nop("gap2",       Z);
        cyc("beq_w",      5'd10, 2'd0, 5'd10, 2'd0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, ex(0, 1, 1, 0, 0, 0, 0));
        flush();

        // writes to $0 never create a dependency
        cyc("add_r0",     5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd1, 1'b0, 1'b0, 1'b0, Z);
        cyc("read_r0",    5'd0, 2'd0, 5'd0, 2'd0, 5'd5, 2'd1, 1'b0, 1'b0, 1'b0, Z);
        flush();

        // mult: 1 + 5 busy cycles with mflo held, released on the next
        cyc("mult",       5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b0, Z);
        for (int i = 0; i < 6; i++) mflo("mult_busy", ex(1, 0, 0, 0, 0, 0, 1));
        mflo("mult_release", Z);
        flush();

        // div: 1 + 10 busy cycles
        cyc("div",        5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, Z);
        for (int i = 0; i < 11; i++) mflo("div_busy", ex(1, 0, 0, 0, 0, 0, 1));
        mflo("div_release", Z);
        flush();

        // reset while the divide counter sits at 4
        cyc("div_b",      5'd1, 2'd1, 5'd2, 2'd1, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1, Z);
        for (int i = 0; i < 7; i++) mflo("div_b_busy", ex(1, 0, 0, 0, 0, 0, 1));
        rst_n = 1'b0;
        mflo("rst_mid_busy", Z);
        mflo("rst_held", Z);
        rst_n = 1'b1;
        mflo("mflo_after_rst", Z);
        flush();

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard controller for the 5-stage MIPS pipeline. Keeps a shadow scoreboard of destination register, Tnew and source registers for the E, M and W pipeline registers.
- From that scoreboard it drives the stall/bubble controls for IF/ID and ID/EX, plus all forwarding-mux selects in the D, E and M stages.
- Owns the HI/LO multiply/divide busy timer and stalls HI/LO-dependent instructions in D while the unit is busy.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu enters E.
- DIV_CYC, 10, busy cycles after a div/divu enters E.
- TUSE_NONE, 3, Tuse code meaning "operand not read".

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- D_Rs  in  5  rs field of the instruction in D.
- D_Rt  in  5  rt field of the instruction in D.
- D_TuseRs  in  2  stage-relative first use of rs: 0 = D, 1 = E, 2 = M, 3 = unused.
- D_TuseRt  in  2  same encoding, for rt.
- D_Dst  in  5  GPR write address of the D instruction; 0 = no write.
- D_Tnew  in  2  cycles after entering E until the result exists: ALU 1, load 2, jal 0.
- D_IsMD  in  1  D instruction uses HI/LO (mult/div/mfhi/mflo/mthi/mtlo).
- D_MDStart  in  1  D instruction is mult/multu/div/divu.
- D_MDOp  in  1  0 = multiply, 1 = divide.
- Stall  out  1  freeze PC and IF/ID; load a bubble into ID/EX.
- FwdD_Rs  out  2  D-stage rs mux select: 0 = GRF, 1 = W, 2 = M (AO or PC8), 3 = E (PC8).
- FwdD_Rt  out  2  same encoding, for rt.
- FwdE_Rs  out  2  E-stage ALU rs mux select: 0 = pipe reg, 1 = W, 2 = M.
- FwdE_Rt  out  2  same encoding, for rt.
- FwdM_Rt  out  1  MEM store-data select: 1 = W result.
- MD_Busy  out  1  HI/LO unit busy.

Behaviour:
- Shadow registers:
  - E: Dst, Tnew, Rs, Rt, Start, Op.
  - M: Dst, Tnew, Rt.
  - W: Dst.
- Every posedge clk:
  - E <= D inputs when Stall = 0; E <= bubble (all fields 0) when Stall = 1.
  - M <= E with Tnew = sat_dec(E.Tnew), floor 0.
  - W.Dst <= M.Dst.
- Reset (rst_n low, asynchronous, takes effect immediately, including mid-busy):
  - All shadow fields 0, MD counter 0, MD state IDLE.
  - With zero scoreboard, all Fwd* = 0, MD_Busy = 0, and Stall = 0 unless the data hazard rule fires on D inputs alone (it cannot, since all Dst = 0).
- Outputs are combinational from the shadow registers and D inputs; zero latency.
- Match(r, X) = (r != 0) && (r == X.Dst). Register $0 never matches, never stalls, never forwards.
- Data stall for operand s in {Rs, Rt} with Tuse != TUSE_NONE:
  - Stall if (Match(s, E) && E.Tnew > Tuse) || (Match(s, M) && M.Tnew > Tuse).
- MD stall: D_IsMD && MD_Busy.
- Stall = OR of the data stall and the MD stall.
- D forwarding priority, evaluated for D_Rs and D_Rt independently:
  - 3 if Match(s, E) && E.Tnew == 0;
  - else 2 if Match(s, M) && M.Tnew == 0;
  - else 1 if Match(s, W);
  - else 0.
- E forwarding, applied to E.Rs and E.Rt:
  - 2 if Match(s, M) && M.Tnew == 0;
  - else 1 if Match(s, W);
  - else 0.
- FwdM_Rt = Match(M.Rt, W).
- MD timer FSM:
  - IDLE -> BUSY on a posedge where E.Start = 1; cnt <= E.Op ? DIV_CYC : MULT_CYC.
  - In BUSY: cnt decrements each cycle; return to IDLE when cnt reaches 1 at a clock edge (cnt becomes 0).
  - MD_Busy = E.Start || (state == BUSY). Total busy time is 1 + LAT cycles.
  - A second start cannot arrive while busy, because the MD stall blocks it in D.
- Simultaneous hazards: data and MD stalls OR together. Forwarding selects stay valid during a stall and never themselves cause a stall.

Decomposition:
- Package hazard_pkg:
  - Tuse/Tnew encodings and TUSE_NONE.
  - FWD_GRF / FWD_W / FWD_M / FWD_E select constants.
  - MULT_CYC and DIV_CYC defaults.
- One sub-module, md_busy_timer: the IDLE/BUSY FSM plus counter.
  - Inputs: clk, rst_n, start, op.
  - Output: busy.
- All scoreboard and forwarding logic stays in pipe_hazard_ctrl.

Test Plan:
- lw $1 (D_Tnew = 2), then add $2,$1,$1 (Tuse 1/1): Stall = 1 for exactly 1 cycle. In the following cycle add is in E with FwdE_Rs = FwdE_Rt = 1.
- add $3 (Tnew 1), then beq $3,$0 (TuseRs = 0): Stall = 1 for 1 cycle. Next cycle Stall = 0 and FwdD_Rs = 2.
- jal (Dst 31, Tnew 0) in E, jr $31 in D (Tuse 0): Stall = 0, FwdD_Rs = 3.
- mult enters E, mflo held in D: MD_Busy = 1 for 6 consecutive cycles with Stall = 1 throughout. div gives 11 cycles. Both release on the next cycle.
- add with Dst = 0, followed by a reader of $0: no stall, all Fwd* = 0.
- Assert rst_n low during div busy at cnt = 4: MD_Busy drops immediately. After reset is released, mflo in D is not stalled.
